// File: rtl/rgb_led_arbiter.sv
// rtl/rgb_led_arbiter.sv - round-robin owner of the shared RGB LED with hold time and per-channel PWM
module rgb_led_arbiter #(
    parameter int PWM_BITS    = 8,
    parameter int PWM_DIV     = 188,
    parameter int HOLD_CYCLES = 4800000
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] color0,
    input  logic [23:0] color1,
    input  logic [23:0] color2,
    output logic [2:0]  grant,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state, state_n;
    logic [1:0]          last, last_n;
    logic [2:0]          grant_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [PWM_BITS-1:0] pwm_cnt, pwm_n;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
    logic [PWM_BITS-1:0] duty_r_n, duty_g_n, duty_b_n;
    logic                led_r_n, led_g_n, led_b_n;

    logic        div_end, period_start, load_ok;
    logic [3:0]  req4;
    logic [1:0]  c1, c2, win, other_win;
    logic [23:0] own_color;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    always_comb begin
        req4      = {1'b0, req};
        c1        = inc3(last);
        c2        = inc3(c1);
        win       = req4[c1] ? c1 : (req4[c2] ? c2 : last);
        other_win = req4[c1] ? c1 : c2;
        case (last)
            2'd0:    own_color = color0;
            2'd1:    own_color = color1;
            default: own_color = color2;
        endcase

        div_end      = (div_cnt == DIV_W'(PWM_DIV - 1));
        div_n        = div_end ? '0 : div_cnt + 1'b1;
        pwm_n        = div_end ? pwm_cnt + 1'b1 : pwm_cnt;
        period_start = div_end && (pwm_cnt == '1);

        state_n  = state;
        grant_n  = grant;
        last_n   = last;
        hold_n   = hold_cnt;
        duty_r_n = duty_r;
        duty_g_n = duty_g;
        duty_b_n = duty_b;
        load_ok  = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = OWN;
                    grant_n = 3'b001 << win;
                    last_n  = win;
                    hold_n  = HOLD_W'(HOLD_CYCLES - 1);
                end
            end
            default: begin
                // An owner dropping its request always yields an idle cycle, even at hold expiry.
                if (!req4[last]) begin
                    state_n  = IDLE;
                    grant_n  = 3'b000;
                    duty_r_n = '0;
                    duty_g_n = '0;
                    duty_b_n = '0;
                end else if (hold_cnt == '0) begin
                    hold_n = HOLD_W'(HOLD_CYCLES - 1);
                    if (req4[c1] || req4[c2]) begin
                        grant_n  = 3'b001 << other_win;
                        last_n   = other_win;
                        duty_r_n = '0;
                        duty_g_n = '0;
                        duty_b_n = '0;
                    end else begin
                        load_ok = 1'b1;
                    end
                end else begin
                    hold_n  = hold_cnt - 1'b1;
                    load_ok = 1'b1;
                end
            end
        endcase

        // Colour is only sampled at a period start while ownership is unchanged.
        if (load_ok && period_start) begin
            duty_r_n = own_color[23 -: PWM_BITS];
            duty_g_n = own_color[15 -: PWM_BITS];
            duty_b_n = own_color[7 -: PWM_BITS];
        end

        led_r_n = !((state_n == OWN) && (pwm_n < duty_r_n));
        led_g_n = !((state_n == OWN) && (pwm_n < duty_g_n));
        led_b_n = !((state_n == OWN) && (pwm_n < duty_b_n));
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= 3'b000;
            last     <= 2'd2;
            hold_cnt <= '0;
            div_cnt  <= '0;
            pwm_cnt  <= '0;
            duty_r   <= '0;
            duty_g   <= '0;
            duty_b   <= '0;
            led_r    <= 1'b1;
            led_g    <= 1'b1;
            led_b    <= 1'b1;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            div_cnt  <= div_n;
            pwm_cnt  <= pwm_n;
            duty_r   <= duty_r_n;
            duty_g   <= duty_g_n;
            duty_b   <= duty_b_n;
            led_r    <= led_r_n;
            led_g    <= led_g_n;
            led_b    <= led_b_n;
        end
    end

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb/tb_rgb_led_arbiter.sv - scoreboard bench for rgb_led_arbiter
module tb_rgb_led_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] color0, color1, color2;
    logic [2:0]  grant;
    logic        led_r, led_g, led_b;

    int tests_run = 0;
    int fails     = 0;
    int ec        = 0;

    typedef struct {
        int         at;
        logic [2:0] g;
        logic [2:0] l;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;

    rgb_led_arbiter #(.PWM_BITS(4), .PWM_DIV(1), .HOLD_CYCLES(8)) dut (
        .clk_48mhz(clk),
        .reset(reset),
        .req(req),
        .color0(color0),
        .color1(color1),
        .color2(color2),
        .grant(grant),
        .led_r(led_r),
        .led_g(led_g),
        .led_b(led_b)
    );

    always #5 clk = ~clk;

    // Edge count since the last reset edge; the PWM counter equals ec mod 16.
    always @(posedge clk) begin
        if (reset) ec <= 0;
        else       ec <= ec + 1;
    end

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at == ec) begin
            e = q.pop_front();
            tests_run++;
            if (grant !== e.g) begin
                fails++;
                $display("FAIL %s grant: got %b want %b", e.name, grant, e.g);
            end
            tests_run++;
            if ({led_r, led_g, led_b} !== e.l) begin
                fails++;
                $display("FAIL %s leds: got %b want %b", e.name, {led_r, led_g, led_b}, e.l);
            end
        end
    end

    task automatic push(input int at, input logic [2:0] g, input logic [2:0] l, input string n);
        exp_t x;
        x.at = at; x.g = g; x.l = l; x.name = n;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (ec != n && guard < 300) begin
            tick();
            guard++;
        end
        if (ec != n) begin
            tests_run++;
            fails++;
            $display("FAIL run_to: got ec %0d want %0d", ec, n);
        end
    endtask

    task automatic do_reset();
        req   = 3'b000;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req    = 3'b000;
        color0 = 24'h0;
        color1 = 24'h0;
        color2 = 24'h0;

        // Rotation under full load
        do_reset();
        push(0, 3'b000, 3'b111, "t1_reset");
        push(1, 3'b001, 3'b111, "t1_first");
        push(8, 3'b001, 3'b111, "t1_hold_end");
        push(9, 3'b010, 3'b111, "t1_to1");
        push(16, 3'b010, 3'b111, "t1_hold1");
        push(17, 3'b100, 3'b111, "t1_to2");
        push(24, 3'b100, 3'b111, "t1_hold2");
        push(25, 3'b001, 3'b111, "t1_wrap");
        req = 3'b111;
        run_to(25);

        // PWM duty R=15, G=8, B=0
        do_reset();
        color1 = 24'hF0_80_00;
        req    = 3'b010;
        push(1, 3'b010, 3'b111, "t2_grant");
        push(15, 3'b010, 3'b111, "t2_pre_period");
        push(16, 3'b010, 3'b001, "t2_start");
        push(23, 3'b010, 3'b001, "t2_g_last");
        push(24, 3'b010, 3'b011, "t2_g_off");
        push(30, 3'b010, 3'b011, "t2_r_last");
        push(31, 3'b010, 3'b111, "t2_r_off");
        push(32, 3'b010, 3'b001, "t2_next");
        run_to(32);

        // Owner drop during hold
        do_reset();
        color1 = 24'h0;
        req    = 3'b101;
        push(1, 3'b001, 3'b111, "t3_grant0");
        push(3, 3'b001, 3'b111, "t3_hold");
        push(4, 3'b000, 3'b111, "t3_gap");
        push(5, 3'b100, 3'b111, "t3_grant2");
        push(12, 3'b100, 3'b111, "t3_fresh_hold");
        push(13, 3'b001, 3'b111, "t3_back0");
        run_to(3);
        req = 3'b100;
        run_to(5);
        req = 3'b101;
        run_to(13);

        // Colour change only at period start
        do_reset();
        color0 = 24'h0;
        req    = 3'b001;
        push(1, 3'b001, 3'b111, "t4_grant");
        push(21, 3'b001, 3'b111, "t4_mid");
        push(31, 3'b001, 3'b111, "t4_pre");
        push(32, 3'b001, 3'b000, "t4_on");
        push(46, 3'b001, 3'b000, "t4_last_on");
        push(47, 3'b001, 3'b111, "t4_off_step");
        push(48, 3'b001, 3'b000, "t4_on_again");
        run_to(20);
        color0 = 24'hFF_FF_FF;
        run_to(48);

        // Reset while lit, then last=2 search order
        reset = 1'b1;
        push(0, 3'b000, 3'b111, "t5_reset");
        push(1, 3'b010, 3'b111, "t5_rr");
        push(9, 3'b100, 3'b111, "t5_next");
        tick();
        reset  = 1'b0;
        color0 = 24'h0;
        req    = 3'b110;
        run_to(9);

        // Drop coinciding with hold expiry
        do_reset();
        req = 3'b011;
        push(1, 3'b001, 3'b111, "t6_grant");
        push(8, 3'b001, 3'b111, "t6_hold_end");
        push(9, 3'b000, 3'b111, "t6_gap");
        push(10, 3'b010, 3'b111, "t6_grant1");
        run_to(8);
        req = 3'b010;
        run_to(10);

        tick();
        tick();
        if (q.size() != 0) begin
            tests_run += q.size();
            fails     += q.size();
            $display("FAIL leftover: got %0d unchecked want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/rgb_led_arbiter.md
Name: rgb_led_arbiter

Overview:
- Shares the board's single RGB LED among three requesters: CPU port, heartbeat and fault/status.
- Round-robin grant with a minimum ownership (hold) time.
- Per-channel PWM brightness taken from the owner's 24-bit colour word.
- Sits between SoC/status logic and the LED_R/LED_G/LED_B pins; drives active-low LEDs directly.

Parameters:
- PWM_BITS, 8: PWM resolution per channel. Duty is the top PWM_BITS of each 8-bit colour field; PWM_BITS must be ≤ 8.
- PWM_DIV, 188: clock cycles per PWM counter step. Default gives ≈1 kHz period at 48 MHz with PWM_BITS=8.
- HOLD_CYCLES, 4800000: minimum cycles an owner keeps the LED before it can be preempted (100 ms).

Ports:
- clk_48mhz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  3  request per requester; level-sensitive, held while ownership is wanted
- color0  in  24  requester 0 colour {R[23:16],G[15:8],B[7:0]}
- color1  in  24  requester 1 colour
- color2  in  24  requester 2 colour
- grant  out  3  one-hot owner, or 0 when idle; registered
- led_r  out  1  red drive, active-low
- led_g  out  1  green drive, active-low
- led_b  out  1  blue drive, active-low

Behaviour:
Reset (sync, active-high):
- state=IDLE, grant=0, led_*=1 (off).
- pwm_cnt=0, div_cnt=0, duty_r/g/b=0, hold_cnt=0, last=2 (so requester 0 wins first).
- Reset asserted mid-ownership drops grant and turns LEDs off on the next edge.

Arbitration order: search last+1, last+2, last (mod 3).

States:
- IDLE:
  - grant=0.
  - If any req bit is set: grant the winner at the next edge, set last=winner, load hold_cnt=HOLD_CYCLES-1, go to OWN.
  - Latency: req seen at edge t → grant valid after edge t+1.
- OWN:
  - hold_cnt decrements by 1 per cycle while nonzero.
  - Owner's req drops, at any time including during hold: next edge gives grant=0, state=IDLE, duty_*=0. Re-arbitration follows one cycle later, so there is always a one-cycle idle gap.
  - hold_cnt==0 and owner still requesting:
    - If another req bit is set, switch directly (no idle gap) to the next requester in round-robin order, reload hold_cnt, and clear duty_*=0.
    - Otherwise stay with the current owner and reload hold_cnt.
- Simultaneous owner drop and hold expiry: the drop wins (IDLE).

PWM:
- div_cnt counts 0..PWM_DIV-1. On wrap, pwm_cnt increments modulo 2^PWM_BITS.
- At pwm_cnt wrap to 0 (period start), if state=OWN, duty_r/g/b load from the owner's colour fields (top PWM_BITS of each). Colour changes therefore take effect only at period boundaries.
- Channel on (led=0) iff state=OWN and pwm_cnt < duty.
  - duty=0 → never on.
  - duty=2^PWM_BITS-1 → on for all but one step per period.
- After any grant change, LEDs stay off until the first period start under the new owner.
- pwm_cnt and div_cnt run freely regardless of state.

Width rules:
- hold_cnt width = clog2(HOLD_CYCLES).
- div_cnt width = clog2(PWM_DIV).
- All counters wrap; there are no saturating counters.

Outputs: all outputs are registered; no combinational path from req or color* to any output.

Test Plan:
Bench parameters: PWM_BITS=4, PWM_DIV=1, HOLD_CYCLES=8.
1. Reset, then req=3'b111 at cycle 0 → grant=3'b001 after edge 1. With owner held, grant moves to 3'b010 after hold expiry (8 cycles), then to 3'b100 after 8 more, then back to 3'b001.
2. req=3'b010 only, color1=24'hF0_80_00 → grant=3'b010 stays constant. From the first period start, per 16-cycle period: led_r low for 15 cycles, led_g low for 8 cycles, led_b always high.
3. Owner 0 drops req at cycle 3 of hold while req[2]=1 → grant=0 for exactly one cycle, then grant=3'b100 with a fresh 8-cycle hold.
4. Mid-period change of color0 from 24'h000000 to 24'hFFFFFF → LEDs stay high until the next pwm_cnt wrap, then all three go low for 15/16 of each period.
5. Assert reset for one cycle while in OWN with LEDs lit → next edge gives grant=0 and led_*=1. After release, req=3'b110 → grant=3'b010 (last=2, so search order is 0, 1, 2).
6. Owner drop coinciding with hold_cnt==0 while another requester is active → grant passes through 0 for one cycle, not a direct switch.
